// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM pipeline stage: memory-op codes,
// FSM state encoding and the data value returned by an aborted bus read.
package mem_access_pkg;

    typedef enum logic [1:0] {
        MEM_OP_NONE  = 2'b00,
        MEM_OP_LOAD  = 2'b01,
        MEM_OP_STORE = 2'b10,
        MEM_OP_RSVD  = 2'b11
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mem_state_e;

    localparam logic       WRITE_ENABLE  = 1'b1;
    localparam logic       WRITE_DISABLE = 1'b0;
    localparam logic       RST_ENABLE    = 1'b0;
    localparam logic       RST_DISABLE   = 1'b1;
    localparam logic [15:0] ERR_DATA     = 16'hFFFF;

    function automatic logic is_mem_op(input mem_op_e op);
        return (op == MEM_OP_LOAD) || (op == MEM_OP_STORE);
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Bus-wait watchdog for mem_access: counts BUSY cycles without an ack and
// flags expiry during the TIMEOUT_CYCLES-th such cycle.
module mem_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic busy,
    input  logic ack,
    output logic expired
);
    import mem_access_pkg::*;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (busy && !ack) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Expiry is seen in the cycle whose missing ack would make the count reach the limit.
    assign expired = busy && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage of the 16-bit core: passes ALU results to MEM/WB and runs a
// req/ack bus transaction for loads and stores. Optional MEM_BUS_TIMEOUT_EN.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int REG_AW         = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [REG_AW-1:0] ex_waddr,
    input  logic              ex_we,
    input  logic [1:0]        ex_mem_op,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    input  logic [DATA_W-1:0] ex_mem_sdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [REG_AW-1:0] mem_waddr,
    output logic              mem_we,
    output logic              stallreq,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_err
);

    mem_op_e     op;
    logic        mem_req;
    mem_state_e  state_q, state_d;
    logic              bus_req_q,   bus_req_d;
    logic              bus_we_q,    bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic              timed_out;

    assign op      = mem_op_e'(ex_mem_op);
    assign mem_req = is_mem_op(op);

`ifdef MEM_BUS_TIMEOUT_EN
    logic bus_err_q, bus_err_d;
    logic expired;

    mem_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .start   ((state_q == ST_IDLE) && mem_req),
        .busy    (state_q == ST_BUSY),
        .ack     (bus_ack),
        .expired (expired)
    );

    assign bus_err   = bus_err_q;
    assign timed_out = bus_err_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign bus_err   = 1'b0;
    assign timed_out = 1'b0;
`endif

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
`ifdef MEM_BUS_TIMEOUT_EN
        bus_err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    state_d     = ST_BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = (op == MEM_OP_STORE);
                    bus_addr_d  = ex_mem_addr;
                    bus_wdata_d = ex_mem_sdata;
                end
            end
            ST_BUSY: begin
                if (bus_ack) begin
                    state_d   = ST_DONE;
                    rdata_d   = bus_rdata;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                end
`ifdef MEM_BUS_TIMEOUT_EN
                else if (expired) begin
                    state_d   = ST_DONE;
                    rdata_d   = DATA_W'(ERR_DATA);
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    bus_err_d = 1'b1;
                end
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_wdata = ex_wdata;
        mem_waddr = ex_waddr;
        mem_we    = ex_we;
        stallreq  = 1'b0;
        if (rst == RST_ENABLE) begin
            mem_wdata = '0;
            mem_waddr = '0;
            mem_we    = WRITE_DISABLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A stalled load/store must not reach the register file early.
                    if (mem_req) begin
                        stallreq = 1'b1;
                        mem_we   = WRITE_DISABLE;
                    end
                end
                ST_BUSY: begin
                    stallreq = 1'b1;
                    mem_we   = WRITE_DISABLE;
                end
                ST_DONE: begin
                    if (op == MEM_OP_LOAD) begin
                        mem_wdata = rdata_q;
                        if (timed_out) mem_we = WRITE_DISABLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
`ifdef MEM_BUS_TIMEOUT_EN
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, loads/stores with wait states,
// spurious acks, async reset mid-transaction, and timeouts under MEM_BUS_TIMEOUT_EN.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ex_wdata, ex_mem_addr, ex_mem_sdata, bus_rdata;
    logic [3:0]  ex_waddr;
    logic        ex_we, bus_ack;
    logic [1:0]  ex_mem_op;
    logic [15:0] mem_wdata, bus_addr, bus_wdata;
    logic [3:0]  mem_waddr;
    logic        mem_we, stallreq, bus_req, bus_we, bus_err;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk          (clk),
        .rst          (rst),
        .ex_wdata     (ex_wdata),
        .ex_waddr     (ex_waddr),
        .ex_we        (ex_we),
        .ex_mem_op    (ex_mem_op),
        .ex_mem_addr  (ex_mem_addr),
        .ex_mem_sdata (ex_mem_sdata),
        .mem_wdata    (mem_wdata),
        .mem_waddr    (mem_waddr),
        .mem_we       (mem_we),
        .stallreq     (stallreq),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack),
        .bus_err      (bus_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; returns in the first non-stalled cycle (DONE).
    // ack_at = BUSY cycle on which bus_ack is pulsed, 0 = never.
    task automatic run_txn(input string tag, input logic [1:0] op, input logic [15:0] addr,
                           input logic [15:0] sdata, input int ack_at, input logic [15:0] rdata,
                           output int stalls, output int busy_cycles);
        ex_mem_op    = op;
        ex_mem_addr  = addr;
        ex_mem_sdata = sdata;
        stalls       = 0;
        busy_cycles  = 0;
        #1;
        while (stallreq && stalls < 40) begin
            stalls++;
            if (bus_req) begin
                busy_cycles++;
                check({tag, " bus_addr"},  bus_addr,  addr);
                check({tag, " bus_we"},    bus_we,    (op == 2'b10));
                check({tag, " bus_wdata"}, bus_wdata, sdata);
                if (busy_cycles == ack_at) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rdata;
                end
            end
            @(negedge clk);
            bus_ack   = 1'b0;
            bus_rdata = 16'h0000;
            #1;
        end
    endtask

    int stalls, busy;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        ex_wdata     = 16'h0005;
        ex_waddr     = 4'd3;
        ex_we        = 1'b1;
        ex_mem_op    = 2'b01;
        ex_mem_addr  = 16'h0040;
        ex_mem_sdata = 16'h0000;
        bus_rdata    = 16'h0000;
        bus_ack      = 1'b0;

        #3;
        check("rst mem_we",    mem_we,    1'b0);
        check("rst mem_wdata", mem_wdata, 16'h0000);
        check("rst mem_waddr", mem_waddr, 4'd0);
        check("rst stallreq",  stallreq,  1'b0);
        check("rst bus_req",   bus_req,   1'b0);
        check("rst bus_we",    bus_we,    1'b0);
        check("rst bus_addr",  bus_addr,  16'h0000);
        check("rst bus_wdata", bus_wdata, 16'h0000);
        check("rst bus_err",   bus_err,   1'b0);

        @(negedge clk);
        rst       = 1'b1;
        ex_mem_op = 2'b00;
        #1;
        check("pass mem_wdata", mem_wdata, 16'h0005);
        check("pass mem_waddr", mem_waddr, 4'd3);
        check("pass mem_we",    mem_we,    1'b1);
        check("pass stallreq",  stallreq,  1'b0);
        @(negedge clk);
        check("pass bus_req", bus_req, 1'b0);
        ex_mem_op = 2'b11;
        ex_wdata  = 16'h0077;
        #1;
        check("rsvd stallreq",  stallreq,  1'b0);
        check("rsvd mem_wdata", mem_wdata, 16'h0077);
        @(negedge clk);
        check("rsvd bus_req", bus_req, 1'b0);

        // Zero-wait load
        ex_wdata = 16'h1111;
        ex_waddr = 4'd2;
        ex_we    = 1'b1;
        run_txn("ld0", 2'b01, 16'h0040, 16'h0000, 1, 16'hBEEF, stalls, busy);
        check("ld0 stalls",    stalls,    2);
        check("ld0 busy",      busy,      1);
        check("ld0 mem_wdata", mem_wdata, 16'hBEEF);
        check("ld0 mem_waddr", mem_waddr, 4'd2);
        check("ld0 mem_we",    mem_we,    1'b1);
        check("ld0 bus_req",   bus_req,   1'b0);
        check("ld0 bus_err",   bus_err,   1'b0);
        @(negedge clk);
        ex_mem_op = 2'b00;

        // Store with ack on the third BUSY cycle
        @(negedge clk);
        ex_wdata = 16'h00AA;
        ex_waddr = 4'd7;
        ex_we    = 1'b0;
        run_txn("st3", 2'b10, 16'h0010, 16'h1234, 3, 16'hDEAD, stalls, busy);
        check("st3 stalls",    stalls,    4);
        check("st3 busy",      busy,      3);
        check("st3 mem_we",    mem_we,    1'b0);
        check("st3 mem_wdata", mem_wdata, 16'h00AA);
        check("st3 mem_waddr", mem_waddr, 4'd7);
        check("st3 bus_we",    bus_we,    1'b0);
        @(negedge clk);
        ex_mem_op = 2'b00;

        // Spurious ack in IDLE
        @(negedge clk);
        ex_wdata  = 16'h0042;
        ex_we     = 1'b1;
        bus_ack   = 1'b1;
        bus_rdata = 16'h9999;
        @(negedge clk);
        bus_ack   = 1'b0;
        #1;
        check("spur stallreq",  stallreq,  1'b0);
        check("spur bus_req",   bus_req,   1'b0);
        check("spur mem_wdata", mem_wdata, 16'h0042);

        // Back-to-back loads; ack also pulsed in the DONE cycle of the first
        @(negedge clk);
        ex_waddr = 4'd5;
        run_txn("bb1", 2'b01, 16'h0100, 16'h0000, 1, 16'hA5A5, stalls, busy);
        check("bb1 stalls",    stalls,    2);
        check("bb1 mem_wdata", mem_wdata, 16'hA5A5);
        check("bb1 mem_we",    mem_we,    1'b1);
        bus_ack   = 1'b1;
        bus_rdata = 16'h1357;
        @(negedge clk);
        bus_ack   = 1'b0;
        bus_rdata = 16'h0000;
        check("bb gap bus_req", bus_req, 1'b0);
        ex_waddr = 4'd6;
        run_txn("bb2", 2'b01, 16'h0102, 16'h0000, 2, 16'h5A5A, stalls, busy);
        check("bb2 stalls",    stalls,    3);
        check("bb2 busy",      busy,      2);
        check("bb2 mem_wdata", mem_wdata, 16'h5A5A);
        check("bb2 mem_waddr", mem_waddr, 4'd6);
        @(negedge clk);
        ex_mem_op = 2'b00;

        // Asynchronous reset in the middle of BUSY
        @(negedge clk);
        ex_mem_op   = 2'b01;
        ex_mem_addr = 16'h0200;
        @(negedge clk);
        check("mid busy bus_req", bus_req, 1'b1);
        #2;
        rst       = 1'b0;
        ex_mem_op = 2'b00;
        #1;
        check("mid rst bus_req",  bus_req,  1'b0);
        check("mid rst stallreq", stallreq, 1'b0);
        check("mid rst mem_we",   mem_we,   1'b0);
        @(negedge clk);
        rst     = 1'b1;
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        check("post rst stallreq", stallreq, 1'b0);
        check("post rst bus_req",  bus_req,  1'b0);
        check("post rst bus_addr", bus_addr, 16'h0000);
        check("post rst mem_wdata", mem_wdata, 16'h0042);

`ifdef MEM_BUS_TIMEOUT_EN
        // Load with no ack: aborted after 15 BUSY cycles
        @(negedge clk);
        ex_waddr = 4'd9;
        ex_we    = 1'b1;
        run_txn("to", 2'b01, 16'h0300, 16'h0000, 0, 16'h0000, stalls, busy);
        check("to stalls",    stalls,    16);
        check("to busy",      busy,      15);
        check("to bus_err",   bus_err,   1'b1);
        check("to mem_wdata", mem_wdata, 16'hFFFF);
        check("to mem_we",    mem_we,    1'b0);
        check("to bus_req",   bus_req,   1'b0);
        @(negedge clk);
        ex_mem_op = 2'b00;
        check("to err pulse", bus_err, 1'b0);

        // Ack on the expiry cycle wins
        @(negedge clk);
        run_txn("to15", 2'b01, 16'h0304, 16'h0000, 15, 16'h2468, stalls, busy);
        check("to15 stalls",    stalls,    16);
        check("to15 bus_err",   bus_err,   1'b0);
        check("to15 mem_wdata", mem_wdata, 16'h2468);
        check("to15 mem_we",    mem_we,    1'b1);
        @(negedge clk);
        ex_mem_op = 2'b00;
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM pipeline stage of the 16-bit core; sits between the EX/MEM register and the MEM/WB register and drives mem_wdata/mem_waddr/mem_we into MEM/WB.
- ALU results pass straight through.
- Loads and stores run a request/acknowledge transaction on the data bus; stallreq holds the pipeline until the transaction completes.

Parameters:
- DATA_W, 16, data and bus word width
- ADDR_W, 16, bus address width
- REG_AW, 4, register-file address width
- TIMEOUT_CYCLES, 15, BUSY cycles before abort (used only with MEM_BUS_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- ex_wdata  in  DATA_W  ALU result / write-back data from EX/MEM
- ex_waddr  in  REG_AW  destination register
- ex_we  in  1  register write enable
- ex_mem_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- ex_mem_addr  in  ADDR_W  memory address
- ex_mem_sdata  in  DATA_W  store data
- mem_wdata  out  DATA_W  to MEM/WB
- mem_waddr  out  REG_AW  to MEM/WB
- mem_we  out  1  to MEM/WB
- stallreq  out  1  pipeline stall request to the stall controller
- bus_req  out  1  bus request (registered)
- bus_we  out  1  1 = write (registered)
- bus_addr  out  ADDR_W  registered address
- bus_wdata  out  DATA_W  registered write data
- bus_rdata  in  DATA_W  read data, valid with bus_ack
- bus_ack  in  1  transaction complete, single-cycle pulse
- bus_err  out  1  timeout pulse (constant 0 without the optional feature)

Behaviour:
- States: IDLE, BUSY, DONE. Reset: state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, internal rdata_q=0, bus_err=0.
- During reset (rst=0): mem_we=0, mem_wdata=0, mem_waddr=0, stallreq=0.
- IDLE, op none or reserved:
  - mem_wdata=ex_wdata, mem_waddr=ex_waddr, mem_we=ex_we, stallreq=0, no bus activity.
- IDLE, op load or store:
  - stallreq=1 (combinational).
  - Next edge: go to BUSY; bus_req<=1; bus_we<=(op==store); bus_addr<=ex_mem_addr; bus_wdata<=ex_mem_sdata.
- BUSY:
  - stallreq=1; bus_ack is sampled only in this state.
  - On ack: rdata_q<=bus_rdata, bus_req<=0, bus_we<=0, go to DONE. An ack in the first BUSY cycle is legal.
  - No ack: hold all bus outputs unchanged.
- DONE:
  - stallreq=0; mem_waddr=ex_waddr, mem_we=ex_we.
  - mem_wdata = rdata_q for a load, ex_wdata for a store.
  - Next edge: go to IDLE unconditionally. The pipeline advances on that edge, so IDLE sees the next instruction.
- Latency with a zero-wait ack: 2 stall cycles per load/store. With ack on the k-th BUSY cycle: k+1 stall cycles.
- EX/MEM inputs are held stable by the stall while stallreq=1. The block must not re-latch bus_addr/bus_wdata outside IDLE.
- Back-to-back memory ops: DONE -> IDLE -> BUSY. The bus is always idle for at least 1 cycle between transactions.
- bus_ack in IDLE or DONE: ignored, no state change.
- Reset mid-transaction: bus_req drops immediately (asynchronous), FSM returns to IDLE, rdata_q=0, and the transaction is abandoned.

Optional Feature:
- MEM_BUS_TIMEOUT_EN defined:
  - A cycle counter, cleared on BUSY entry, increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES: go to DONE; rdata_q<=16'hFFFF; bus_req<=0; bus_err=1 for exactly the DONE cycle.
  - In DONE after a timeout, mem_we is forced to 0 for a load.
  - An ack in the same cycle as expiry wins: normal completion, no error.
- Not defined: BUSY waits indefinitely; bus_err tied to 0; no counter logic.

Decomposition:
- Shared defines file (defines.v): MemOpNone/MemOpLoad/MemOpStore codes, FSM state encodings, existing WriteEnable/WriteDisable, RstEnable/RstDisable (RstEnable = 1'b0 for this block), and the 16'hFFFF error-data constant.
- One sub-module, mem_timeout_cnt (counter plus expiry compare), instantiated only under MEM_BUS_TIMEOUT_EN.

Test Plan:
- Pass-through: reset released, op=00, ex_wdata=16'h0005, ex_waddr=3, ex_we=1 -> same cycle mem_wdata=5, mem_waddr=3, mem_we=1, stallreq=0, bus_req stays 0.
- Zero-wait load: op=01, addr=16'h0040, waddr=2, ack on first BUSY cycle with bus_rdata=16'hBEEF -> stallreq high for 2 cycles, bus_req high for 1 cycle with bus_we=0 and bus_addr=16'h0040; in DONE mem_wdata=16'hBEEF, mem_waddr=2, mem_we=1.
- Store with 3-cycle wait: op=10, addr=16'h0010, sdata=16'h1234, ex_we=0, ack on 3rd BUSY cycle -> bus_we=1, bus_wdata=16'h1234 held 3 cycles, stallreq high 4 cycles, mem_we=0 in DONE.
- Spurious ack plus back-to-back loads: ack pulsed in IDLE -> no effect; two consecutive loads -> bus_req low for at least 1 cycle between transactions, each result correct.
- Reset mid-BUSY: rst=0 while bus_req=1 -> bus_req=0 and stallreq=0 without waiting for a clock edge; after release state is IDLE and a later ack is ignored.
- Timeout (MEM_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=15): load with no ack -> after 15 BUSY cycles bus_err pulses 1 cycle, mem_wdata=16'hFFFF, mem_we=0; repeat with ack on cycle 15 -> normal completion, bus_err=0.
